// File: rtl/bram_mem_port_pkg.sv
// Shared types and helpers for the bram_mem_port block:
// FSM state encoding, byte-lane count, per-byte parity and legal read latencies.
package mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RL_ONE = 1;
  localparam int RL_TWO = 2;

  // Number of byte lanes in a word of width dw (dw is a multiple of 8).
  function automatic int nb_of(input int dw);
    return dw / 8;
  endfunction

  // Even-parity bit: byte plus this bit always holds an even number of ones.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/bram_mem_port_if.sv
// Request/response bus of bram_mem_port: valid/ready request channel and
// an unbackpressured read-response channel.
interface bram_mem_port_if #(
  parameter int WORDS      = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [NB-1:0]         req_be_i;
  logic [WORDS-1:0]      req_addr_i;
  logic [DATA_WIDTH-1:0] req_data_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_data_o;

  modport master (
    output req_valid_i, req_we_i, req_be_i, req_addr_i, req_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_be_i, req_addr_i, req_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/bram_mem_port_mem_array.sv
// mem_array: raw single-port storage with per-lane write enables and a
// registered synchronous read. Each lane is LANE_W bits wide (8, or 9 when a
// parity bit rides along with the byte).
module mem_array #(
  parameter int ADDR_W = 10,
  parameter int NB     = 4,
  parameter int LANE_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NB-1:0]        we_i,
  input  logic                 re_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [NB*LANE_W-1:0] wdata_i,
  output logic [NB*LANE_W-1:0] rdata_o
);

  logic [NB*LANE_W-1:0] mem [2**ADDR_W];

  // Lane-wise write: only enabled lanes are updated.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NB; k++) begin
      if (we_i[k]) mem[addr_i][k*LANE_W +: LANE_W] <= wdata_i[k*LANE_W +: LANE_W];
    end
  end

  // Read register: loads only on a read so the output holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_o <= '0;
    else if (re_i) rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/bram_mem_port.sv
// bram_mem_port: single-port BRAM behind a valid/ready request bus with
// byte enables, 1- or 2-cycle read latency and a post-reset clear engine.
// Optional per-byte even parity is enabled by defining MEM_PARITY_EN.
module bram_mem_port
  import mem_pkg::*;
#(
  parameter int WORDS          = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  bram_mem_port_if.slave   bus,
  output logic             busy_o,
  output logic             parity_err_o
);

  localparam int NB = nb_of(DATA_WIDTH);
`ifdef MEM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int MEM_W = NB * LANE_W;
  localparam logic [WORDS:0] CNT_ONE = {{WORDS{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [WORDS:0]        cnt_q, cnt_d;
  logic                  ready, busy, rd_acc;
  logic [NB-1:0]         mem_we;
  logic [WORDS-1:0]      mem_addr;
  logic [MEM_W-1:0]      wr_word, mem_wdata, mem_rdata_p0;
  logic [DATA_WIDTH-1:0] data_p0, rsp_data;
  logic                  perr_p0, vld_p0, rsp_vld, rsp_perr;

  // Pack request bytes into lanes, appending each lane's parity when enabled.
  always_comb begin
    wr_word = '0;
    for (int k = 0; k < NB; k++) begin
      wr_word[k*LANE_W +: 8] = bus.req_data_i[k*8 +: 8];
`ifdef MEM_PARITY_EN
      wr_word[k*LANE_W + 8] = even_par(bus.req_data_i[k*8 +: 8]);
`endif
    end
  end

  // Next-state and array control: clear sweep in CLEAR, request decode in READY.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready     = 1'b0;
    busy      = 1'b0;
    rd_acc    = 1'b0;
    mem_we    = '0;
    mem_addr  = bus.req_addr_i;
    mem_wdata = wr_word;
    case (state_q)
      CLEAR: begin
        busy      = 1'b1;
        mem_we    = {NB{1'b1}};
        mem_addr  = cnt_q[WORDS-1:0];
        mem_wdata = '0;
        cnt_d     = cnt_q + CNT_ONE;
        // Extra counter bit flags that the last address has just been written.
        if (cnt_d[WORDS]) state_d = READY;
      end
      READY: begin
        ready = ~reset_i;
        if (bus.req_valid_i && ready) begin
          if (bus.req_we_i) mem_we = bus.req_be_i;
          else              rd_acc = 1'b1;
        end
      end
      default: state_d = READY;
    endcase
    if (reset_i) begin
      mem_we = '0;
      rd_acc = 1'b0;
    end
  end

  // State and clear-counter registers; reset restarts the sweep at address 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mem_array #(
    .ADDR_W (WORDS),
    .NB     (NB),
    .LANE_W (LANE_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .we_i    (mem_we),
    .re_i    (rd_acc),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata_p0)
  );

  // ---- stage p0: array read register output ----
  // Unpack lanes and recompute parity on the word leaving the array.
  always_comb begin
    data_p0 = '0;
    perr_p0 = 1'b0;
    for (int k = 0; k < NB; k++) begin
      data_p0[k*8 +: 8] = mem_rdata_p0[k*LANE_W +: 8];
`ifdef MEM_PARITY_EN
      if (even_par(mem_rdata_p0[k*LANE_W +: 8]) != mem_rdata_p0[k*LANE_W + 8]) perr_p0 = 1'b1;
`endif
    end
  end

  // Read-valid tracking for the array register stage.
  always_ff @(posedge clk_i) begin
    if (reset_i) vld_p0 <= 1'b0;
    else         vld_p0 <= rd_acc;
  end

  // ---- stage p1: optional output register ----
  if (READ_LATENCY == RL_TWO) begin : g_lat2
    logic                  vld_p1, perr_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    // Output register captures only valid reads so data holds between pulses.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
        perr_p1 <= 1'b0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) begin
          data_p1 <= data_p0;
          perr_p1 <= perr_p0;
        end
      end
    end

    assign rsp_vld  = vld_p1;
    assign rsp_data = data_p1;
    assign rsp_perr = perr_p1;
  end else begin : g_lat1
    assign rsp_vld  = vld_p0;
    assign rsp_data = data_p0;
    assign rsp_perr = perr_p0;
  end

  assign bus.req_ready_o = ready;
  assign bus.rsp_valid_o = rsp_vld & ~reset_i;
  assign bus.rsp_data_o  = rsp_data;
  assign busy_o          = busy;
  assign parity_err_o    = rsp_vld & rsp_perr & ~reset_i;

endmodule

// File: tb/tb_bram_mem_port.sv
// Testbench for bram_mem_port (WORDS=4, 32-bit, READ_LATENCY=2, clear on reset).
// Directed requests push expected responses into a scoreboard queue; a
// negedge monitor pops and compares data, parity flag and arrival cycle.
module tb_bram_mem_port;

  localparam int WORDS = 4;
  localparam int DW    = 32;
  localparam int RL    = 2;

  typedef struct {
    logic [31:0] data;
    logic        perr;
    int          due;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic busy, perr;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sbq[$];

  bram_mem_port_if #(.WORDS(WORDS), .DATA_WIDTH(DW)) ifc ();

  bram_mem_port #(
    .WORDS          (WORDS),
    .DATA_WIDTH     (DW),
    .READ_LATENCY   (RL),
    .CLEAR_ON_RESET (1)
  ) u_dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .bus          (ifc.slave),
    .busy_o       (busy),
    .parity_err_o (perr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (ifc.rsp_valid_o === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got data 0x%08h with no response expected", ifc.rsp_data_o);
      end else begin
        e = sbq.pop_front();
        check({e.name, "_data"}, ifc.rsp_data_o, e.data);
        check({e.name, "_perr"}, {31'b0, perr}, {31'b0, e.perr});
        check({e.name, "_cycle"}, cyc, e.due);
      end
    end else if (perr !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL perr_idle: got %b expected 0 while no response", perr);
    end
  end

  task automatic idle();
    ifc.req_valid_i = 1'b0;
    ifc.req_we_i    = 1'b0;
    ifc.req_be_i    = '0;
    ifc.req_addr_i  = '0;
    ifc.req_data_i  = '0;
  endtask

  // Present one request (called #1 after a posedge), wait for acceptance,
  // leave valid asserted so calls can be chained back-to-back.
  task automatic issue(input logic we, input logic [3:0] be, input logic [3:0] addr,
                       input logic [31:0] data, input logic [31:0] exp, input logic exp_perr,
                       input string name, input bit expect_rsp);
    int guard = 0;
    ifc.req_valid_i = 1'b1;
    ifc.req_we_i    = we;
    ifc.req_be_i    = be;
    ifc.req_addr_i  = addr;
    ifc.req_data_i  = data;
    while (ifc.req_ready_o !== 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: ready=%b after 100 cycles, expected 1", name, ifc.req_ready_o);
    end
    @(posedge clk);
    #1;
    if (!we && expect_rsp) sbq.push_back('{exp, exp_perr, cyc + RL - 1, name});
  endtask

  task automatic wr(input logic [3:0] be, input logic [3:0] addr, input logic [31:0] data);
    issue(1'b1, be, addr, data, 32'h0, 1'b0, "wr", 1'b0);
  endtask

  task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input logic exp_perr,
                    input string name);
    issue(1'b0, 4'h0, addr, 32'h0, exp, exp_perr, name, 1'b1);
  endtask

  // Count busy cycles from the current point; a full sweep of 16 words is expected.
  task automatic count_clear(input string name);
    int n = 0;
    int guard = 0;
    @(negedge clk);
    while (busy === 1'b1 && ifc.req_ready_o === 1'b0 && guard < 100) begin
      n++;
      guard++;
      @(negedge clk);
    end
    check({name, "_cycles"}, n, 32'd16);
    check({name, "_ready_after"}, {31'b0, ifc.req_ready_o}, 32'd1);
    check({name, "_busy_after"}, {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ifc.req_ready_o}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_rsp_valid", {31'b0, ifc.rsp_valid_o}, 32'd0);
    check("rst_rsp_data", ifc.rsp_data_o, 32'h0);
    check("rst_perr", {31'b0, perr}, 32'd0);
    reset = 1'b0;
    count_clear("clear1");

    rd(4'd5, 32'h0000_0000, 1'b0, "clear_rd5");

    wr(4'b1111, 4'd3, 32'hDEAD_BEEF);
    wr(4'b0001, 4'd3, 32'h0000_00AA);
    rd(4'd3, 32'hDEAD_BEAA, 1'b0, "be_lane0");
    wr(4'b0000, 4'd3, 32'h1111_1111);
    rd(4'd3, 32'hDEAD_BEAA, 1'b0, "be_zero");
    wr(4'b1010, 4'd4, 32'h1234_5678);
    rd(4'd4, 32'h1200_5600, 1'b0, "be_1010");

    wr(4'b1111, 4'd0, 32'h0000_0010);
    wr(4'b1111, 4'd1, 32'h0000_0011);
    wr(4'b1111, 4'd2, 32'h0000_0012);
    wr(4'b1111, 4'd3, 32'h0000_0013);
    rd(4'd0, 32'h0000_0010, 1'b0, "pipe0");
    rd(4'd1, 32'h0000_0011, 1'b0, "pipe1");
    rd(4'd2, 32'h0000_0012, 1'b0, "pipe2");
    rd(4'd3, 32'h0000_0013, 1'b0, "pipe3");

    wr(4'b1111, 4'd7, 32'h1234_5678);
    rd(4'd7, 32'h1234_5678, 1'b0, "raw");
    idle();
    repeat (4) @(posedge clk);
    #1;
    check("hold_data", ifc.rsp_data_o, 32'h1234_5678);

    issue(1'b0, 4'h0, 4'd3, 32'h0, 32'h0, 1'b0, "mid_rd", 1'b0);
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    check("mid_busy", {31'b0, busy}, 32'd1);
    check("mid_rsp_data", ifc.rsp_data_o, 32'h0);
    reset = 1'b0;
    count_clear("clear2");
    rd(4'd3, 32'h0000_0000, 1'b0, "mid_cleared");
    rd(4'd7, 32'h0000_0000, 1'b0, "mid_cleared7");

    wr(4'b1111, 4'd2, 32'hFF00_FF00);
    rd(4'd2, 32'hFF00_FF00, 1'b0, "par_clean");
    idle();
    repeat (3) @(posedge clk);
    #1;
`ifdef MEM_PARITY_EN
    u_dut.u_array.mem[2][0] = ~u_dut.u_array.mem[2][0];
    rd(4'd2, 32'hFF00_FF01, 1'b1, "par_flip");
`else
    rd(4'd2, 32'hFF00_FF00, 1'b0, "par_off");
`endif
    idle();
    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_mem_port.md
Name: bram_mem_port

Overview:
Parametrised successor to the team's Nx32 BRAM memory: a single-port synchronous block RAM behind a valid/ready request interface. Adds per-byte write enables, configurable read latency (1 or 2 cycles), and a hardware clear engine that zeroes the array after reset. Sits between the CPU load/store unit or a bus bridge and on-chip BRAM. All logic is on the rising edge; strobes are active-high.

Parameters:
WORDS, 10, address width in bits; depth = 2^WORDS words
DATA_WIDTH, 32, word width in bits; must be a multiple of 8; byte lanes NB = DATA_WIDTH/8
READ_LATENCY, 1, cycles from read acceptance to rsp_valid_o; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip clearing and go straight to ready

Ports:
clk_i  input  1  clock, all logic on posedge
reset_i  input  1  synchronous, active-high reset
req_valid_i  input  1  request present
req_ready_o  output  1  block can accept a request this cycle
req_we_i  input  1  1 = write, 0 = read
req_be_i  input  NB  byte enables (writes only)
req_addr_i  input  WORDS  word address
req_data_i  input  DATA_WIDTH  write data
rsp_valid_o  output  1  one-cycle pulse: read data valid
rsp_data_o  output  DATA_WIDTH  read data
busy_o  output  1  clear engine running
parity_err_o  output  1  parity mismatch on the current response (see Optional Feature)

Behaviour:
- Reset values: req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, parity_err_o=0, pipeline valids=0, clear counter=0. busy_o=1 if CLEAR_ON_RESET, else 0.
- FSM has two states, CLEAR and READY.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - CLEAR: each cycle writes 0 (all lanes) at the clear counter, then increments it. After writing address 2^WORDS-1, moves to READY on the next cycle.
  - CLEAR lasts exactly 2^WORDS cycles with busy_o=1 and req_ready_o=0.
  - READY: req_ready_o=1, busy_o=0.
- Acceptance occurs when req_valid_i & req_ready_o; at most one request per cycle.
- Write:
  - Each byte lane with req_be_i[k]=1 is updated at the acceptance edge; other lanes keep their value.
  - be=0 is accepted as a no-op.
  - A write produces no response.
- Read:
  - req_be_i is ignored.
  - rsp_valid_o pulses exactly READ_LATENCY cycles after acceptance, with rsp_data_o = full word.
  - Back-to-back reads each cycle give consecutive in-order pulses.
  - There is no response backpressure.
- rsp_data_o holds its last value while rsp_valid_o=0.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. Same-cycle conflicts cannot occur (single port).
- READ_LATENCY=2 adds one output register stage after the array read register.
- Reset mid-operation: in-flight reads are dropped (no rsp_valid_o), and the clear restarts at address 0.
- Address width equals WORDS, so no out-of-range handling is needed. The clear counter is WORDS+1 bits to detect terminal count without wrap.

Optional Feature:
Macro MEM_PARITY_EN.
- Defined:
  - The array stores NB extra bits, one even-parity bit per byte, written with each enabled lane; clear writes parity 0.
  - On read, parity is recomputed. parity_err_o pulses aligned with rsp_valid_o if any lane mismatches, otherwise 0.
- Undefined: no parity storage; parity_err_o is tied 0; the port remains present.

Decomposition:
- Package mem_pkg holds:
  - state_t enum {CLEAR, READY}
  - functions for NB and for per-byte parity
  - localparams for the legal READ_LATENCY values
- One sub-module, mem_array: raw storage with per-lane write enable and registered synchronous read, width DATA_WIDTH (+NB when MEM_PARITY_EN).
- FSM, clear counter, and latency pipeline stay in bram_mem_port.

Test Plan:
- Clear: WORDS=4, CLEAR_ON_RESET=1, reset 2 cycles → busy_o=1 and req_ready_o=0 for exactly 16 cycles; then read addr 5 → rsp_data_o=0x00000000 after READ_LATENCY.
- Byte enables: write 0xDEADBEEF be=4'b1111 addr 3, then write 0x000000AA be=4'b0001 addr 3, read addr 3 → 0xDEADBEAA.
- Pipelined reads: READ_LATENCY=2, preload addrs 0..3 with 0x10,0x11,0x12,0x13, reads on 4 consecutive cycles → rsp_valid_o high 4 consecutive cycles starting 2 cycles after the first acceptance, data in order.
- RAW: write 0x12345678 addr 7 in cycle N, read addr 7 accepted in N+1 → 0x12345678.
- Reset mid-flight: accept read, assert reset_i the next cycle → no rsp_valid_o pulse; busy_o re-asserts and clear restarts at 0.
- Parity (MEM_PARITY_EN): write 0xFF00FF00 addr 2, flip one data bit of addr 2 in mem_array via the testbench, read addr 2 → parity_err_o=1 coincident with rsp_valid_o. Macro undefined → parity_err_o stays 0.
